// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
package alu_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Common ALU slice function selects (S_ADD/S_SUB with M=0, S_XOR with M=1).
    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic [3:0] S_XOR = 4'b0110;

endpackage

// File: rtl/alu_seq_nibble_mux.sv
// Picks nibble idx_i out of the latched wide A/B operands; purely combinational.
module alu_seq_nibble_mux
    import alu_seq_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int IDX_W   = 3
) (
    input  logic [NIBBLE_W*NIBBLES-1:0] a_i,
    input  logic [NIBBLE_W*NIBBLES-1:0] b_i,
    input  logic [IDX_W-1:0]            idx_i,
    output logic [NIBBLE_W-1:0]         a_o,
    output logic [NIBBLE_W-1:0]         b_o
);

    always_comb begin
        a_o = '0;
        b_o = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_i == IDX_W'(i)) begin
                a_o = a_i[i*NIBBLE_W +: NIBBLE_W];
                b_o = b_i[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Runs one wide ALU operation through an external 4-bit ALU slice, one nibble per clock, LSB first.
// Optional feature: define ALU_SEQ_ABORT_EN to add an abort input that cancels a running operation.
module alu_nibble_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
`ifdef ALU_SEQ_ABORT_EN
    input  logic                        abort,
`endif
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NIBBLE_W*NIBBLES-1:0] op_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] op_b,
    input  logic [3:0]                  op_s,
    input  logic                        op_m,
    input  logic                        op_cin_n,
    output logic [3:0]                  alu_a,
    output logic [3:0]                  alu_b,
    output logic [3:0]                  alu_s,
    output logic                        alu_m,
    output logic                        alu_cin_n,
    input  logic [3:0]                  alu_y,
    input  logic                        alu_co_n,
    input  logic                        alu_aeqb,
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLE_W*NIBBLES-1:0] result,
    output logic                        result_co_n,
    output logic                        result_aeqb
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES) + 1;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [W-1:0]       a_q, b_q;
    logic [3:0]         s_q;
    logic               m_q;
    logic               carry_n_q;
    logic               aeqb_acc_q;
    logic [W-1:0]       result_q, result_d;
    logic               result_co_n_q;
    logic               result_aeqb_q;
    logic               busy_q, done_q;

    logic [3:0]         nib_a, nib_b;
    logic               last_nib;
    logic               abort_w;

`ifdef ALU_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    alu_seq_nibble_mux #(
        .NIBBLES (NIBBLES),
        .IDX_W   (IDX_W)
    ) u_mux (
        .a_i   (a_q),
        .b_i   (b_q),
        .idx_i (idx_q),
        .a_o   (nib_a),
        .b_o   (nib_b)
    );

    assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

    // Slot the incoming slice output into the nibble currently being processed.
    always_comb begin
        result_d = result_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                result_d[i*NIBBLE_W +: NIBBLE_W] = alu_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            s_q           <= '0;
            m_q           <= 1'b0;
            carry_n_q     <= 1'b1;
            aeqb_acc_q    <= 1'b0;
            result_q      <= '0;
            result_co_n_q <= 1'b1;
            result_aeqb_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q       <= RUN;
                        busy_q        <= 1'b1;
                        idx_q         <= '0;
                        a_q           <= op_a;
                        b_q           <= op_b;
                        s_q           <= op_s;
                        m_q           <= op_m;
                        carry_n_q     <= op_cin_n;
                        aeqb_acc_q    <= 1'b1;
                        result_q      <= '0;
                        result_co_n_q <= 1'b1;
                        result_aeqb_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort_w) begin
                        // Drop the partial result so outputs return to their accept-time values.
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        result_q <= '0;
                    end else begin
                        result_q   <= result_d;
                        carry_n_q  <= alu_co_n;
                        aeqb_acc_q <= aeqb_acc_q & alu_aeqb;
                        idx_q      <= idx_q + IDX_W'(1);
                        if (last_nib) begin
                            state_q       <= DONE;
                            done_q        <= 1'b1;
                            result_co_n_q <= alu_co_n;
                            result_aeqb_q <= aeqb_acc_q & alu_aeqb;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // The slice sees neutral inputs whenever no operation is in flight.
    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_s     = '0;
        alu_m     = 1'b0;
        alu_cin_n = 1'b1;
        if (state_q == RUN) begin
            alu_a     = nib_a;
            alu_b     = nib_b;
            alu_s     = s_q;
            alu_m     = m_q;
            alu_cin_n = carry_n_q;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign result_co_n = result_co_n_q;
    assign result_aeqb = result_aeqb_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Scoreboard bench for alu_nibble_sequencer with a behavioural 4-bit ALU slice attached.
module tb_alu_nibble_sequencer;
    import alu_seq_pkg::*;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic [3:0]   op_s;
    logic         op_m, op_cin_n;
    logic [3:0]   alu_a, alu_b, alu_s, alu_y;
    logic         alu_m, alu_cin_n, alu_co_n, alu_aeqb;
    logic         busy, done, result_co_n, result_aeqb;
    logic [W-1:0] result;
`ifdef ALU_SEQ_ABORT_EN
    logic         abort = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_nibble_sequencer #(.NIBBLES(N)) dut (
`ifdef ALU_SEQ_ABORT_EN
        .abort       (abort),
`endif
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_s        (op_s),
        .op_m        (op_m),
        .op_cin_n    (op_cin_n),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_s       (alu_s),
        .alu_m       (alu_m),
        .alu_cin_n   (alu_cin_n),
        .alu_y       (alu_y),
        .alu_co_n    (alu_co_n),
        .alu_aeqb    (alu_aeqb),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .result_co_n (result_co_n),
        .result_aeqb (result_aeqb)
    );

    // 4-bit ALU slice: F = X plus Y plus Cn (arith) or ~(X^Y) (logic); A=B is F==1111.
    logic [3:0] sx, sy;
    logic [4:0] ssum;
    always_comb begin
        sx       = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
        sy       = (alu_a & alu_b & {4{alu_s[3]}}) | (alu_a & ~alu_b & {4{alu_s[2]}});
        ssum     = {1'b0, sx} + {1'b0, sy} + {4'b0, ~alu_cin_n};
        alu_y    = alu_m ? ~(sx ^ sy) : ssum[3:0];
        alu_co_n = ~ssum[4];
        alu_aeqb = (alu_y == 4'hF);
    end

    typedef struct {
        logic [W-1:0] res;
        logic         co_n;
        logic         aeqb;
        int           dcyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Whole-word reference: the slice function applied to the full operand width with one carry chain.
    function automatic exp_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [3:0] s, input logic m, input logic cin_n);
        exp_t          e;
        logic [W-1:0]  x, y;
        logic [W:0]    sum;
        x      = a | (b & {W{s[0]}}) | (~b & {W{s[1]}});
        y      = (a & b & {W{s[3]}}) | (a & ~b & {W{s[2]}});
        sum    = {1'b0, x} + {1'b0, y} + (W+1)'(!cin_n);
        e.res  = m ? ~(x ^ y) : sum[W-1:0];
        e.co_n = ~sum[W];
        e.aeqb = 1'b1;
        for (int i = 0; i < N; i++) e.aeqb = e.aeqb & (e.res[4*i +: 4] == 4'hF);
        e.dcyc = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: done=1 with nothing outstanding, required 0");
            end else begin
                e = q.pop_front();
                check("result",      32'(result),      32'(e.res));
                check("result_co_n", 32'(result_co_n), 32'(e.co_n));
                check("result_aeqb", 32'(result_aeqb), 32'(e.aeqb));
                check("done_cycle",  32'(cyc),         32'(e.dcyc));
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, budget);
        end
    endtask

    // Called at a negedge; pulses start for one cycle, optionally registering the expectation.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                         input logic m, input logic cin_n, input logic push, input exp_t e_in);
        exp_t e;
        e        = e_in;
        op_a     = a;
        op_b     = b;
        op_s     = s;
        op_m     = m;
        op_cin_n = cin_n;
        start    = 1'b1;
        e.dcyc   = cyc + 1 + N;
        if (push) q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                          input logic m, input logic cin_n, input exp_t e);
        issue(a, b, s, m, cin_n, 1'b1, e);
        wait_idle(N + 6);
        @(negedge clk);
        check("result_hold", 32'(result), 32'(e.res));
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic z);
        exp_t e;
        e.res  = r;
        e.co_n = c;
        e.aeqb = z;
        e.dcyc = 0;
        return e;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        exp_t e;
        logic [W-1:0] ra, rb;
        logic [3:0]   rs;
        logic         rm, rc;

        rst = 1'b1; start = 1'b0;
        op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0; op_cin_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_done",    32'(done),        32'd0);
        check("rst_result",  32'(result),      32'd0);
        check("rst_co_n",    32'(result_co_n), 32'd1);
        check("rst_aeqb",    32'(result_aeqb), 32'd0);
        check("rst_alu_cin", 32'(alu_cin_n),   32'd1);
        rst = 1'b0;
        @(negedge clk);

        run_op(16'h1234, 16'h0FFF, S_ADD, 1'b0, 1'b1, mk(16'h2233, 1'b1, 1'b0));
        run_op(16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b1, mk(16'h0000, 1'b0, 1'b0));
        run_op(16'h0005, 16'h0003, S_SUB, 1'b0, 1'b0, mk(16'h0002, 1'b0, 1'b0));
        run_op(16'hABCD, 16'hABCD, S_SUB, 1'b0, 1'b1, mk(16'hFFFF, 1'b1, 1'b1));

        // XOR with a second start pulsed mid-run that must be ignored.
        issue(16'hF0F0, 16'hFF00, S_XOR, 1'b1, 1'b1, 1'b1, mk(16'h0FF0, 1'b1, 1'b0));
        @(negedge clk);
        op_a = 16'h1111; op_b = 16'h2222; op_s = S_ADD; op_m = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(N + 6);
        repeat (2) @(negedge clk);
        check("ignored_start_busy", 32'(busy),   32'd0);
        check("ignored_start_res",  32'(result), 32'h0FF0);

        // Reset after the second nibble has been captured.
        issue(16'h1234, 16'h1111, S_ADD, 1'b0, 1'b1, 1'b0, mk('0, 1'b1, 1'b0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy",   32'(busy),        32'd0);
        check("midrst_done",   32'(done),        32'd0);
        check("midrst_result", 32'(result),      32'd0);
        check("midrst_co_n",   32'(result_co_n), 32'd1);
        check("midrst_alu_a",  32'(alu_a),       32'd0);
        @(negedge clk);
        check("midrst_still_idle", 32'(busy), 32'd0);
        run_op(16'h0100, 16'h00FF, S_ADD, 1'b0, 1'b1, mk(16'h01FF, 1'b1, 1'b0));

`ifdef ALU_SEQ_ABORT_EN
        issue(16'h4321, 16'h1111, S_ADD, 1'b0, 1'b1, 1'b0, mk('0, 1'b1, 1'b0));
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy",   32'(busy),        32'd0);
        check("abort_result", 32'(result),      32'd0);
        check("abort_co_n",   32'(result_co_n), 32'd1);
        check("abort_aeqb",   32'(result_aeqb), 32'd0);
        repeat (2) @(negedge clk);
        run_op(16'h4321, 16'h1111, S_ADD, 1'b0, 1'b1, mk(16'h5432, 1'b1, 1'b0));
`endif

        for (int k = 0; k < 24; k++) begin
            ra = W'($urandom);
            rb = (k % 6 == 0) ? ~ra : W'($urandom);
            rs = 4'($urandom_range(0, 15));
            rm = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            e  = ref_op(ra, rb, rs, rm, rc);
            run_op(ra, rb, rs, rm, rc, e);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
